// File: rtl/int_ret_pkg.sv
// Shared CSR addresses, mstatus/mcause field positions and int_ret state encodings.
// Also holds helpers for the mstatus restore value and the redirect target (INT_RET_MEPC_ALIGN_EN).
package int_ret_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MCAUSE_EXT_INT   = 11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_MSTATUS = 4'b0010,
    S_CMPL    = 4'b0100,
    S_JUMP    = 4'b1000
  } state_e;

  // mret semantics: MIE takes the old MPIE, MPIE is set to 1.
  function automatic logic [31:0] mstatus_ret(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE_BIT]  = m[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] ret_addr(input logic [31:0] mepc);
    logic [31:0] r;
    r = mepc;
`ifdef INT_RET_MEPC_ALIGN_EN
    r[1:0] = 2'b00;
`endif
    return r;
  endfunction

endpackage

// File: rtl/int_ret_tmo.sv
// Clearable saturating cycle counter with terminal-count flag for the completion wait.
// TMO=0 disables the terminal count entirely.
module int_ret_tmo #(
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TMO == 0) ? {CW{1'b1}} : CW'(TMO - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (TMO != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/int_ret.sv
// Interrupt-return sequencer: restores mstatus, completes the serviced ID, redirects to mepc.
// Optional INT_RET_MEPC_ALIGN_EN forces a word-aligned redirect target.
module int_ret
  import int_ret_pkg::*;
#(
  parameter int ID_W     = 1,
  parameter int CMPL_TMO = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_mret_i,
  input  logic            int_busy_i,
  input  logic [ID_W-1:0] int_id_i,
  input  logic [31:0]     csr_mepc_i,
  input  logic [31:0]     csr_mstatus_i,
  input  logic [31:0]     csr_mcause_i,
  input  logic            cmpl_ready_i,
  output logic            csr_we_o,
  output logic [31:0]     csr_waddr_o,
  output logic [31:0]     csr_wdata_o,
  output logic            cmpl_valid_o,
  output logic [ID_W-1:0] cmpl_id_o,
  output logic            cmpl_err_o,
  output logic            stall_flag_o,
  output logic            int_assert_o,
  output logic [31:0]     int_addr_o
);

  state_e          state_q, state_d;
  logic [31:0]     mepc_q, mepc_d;
  logic [31:0]     mstatus_q, mstatus_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            cause_ext_q, cause_ext_d;

  logic            csr_we_q, csr_we_d;
  logic [31:0]     csr_waddr_q, csr_waddr_d;
  logic [31:0]     csr_wdata_q, csr_wdata_d;
  logic            cmpl_valid_q, cmpl_valid_d;
  logic [ID_W-1:0] cmpl_id_q, cmpl_id_d;
  logic            cmpl_err_q, cmpl_err_d;
  logic            int_assert_q, int_assert_d;
  logic [31:0]     int_addr_q, int_addr_d;

  logic tmo_tc;
  logic tmo_clr;

  int_ret_tmo #(.TMO(CMPL_TMO)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmo_clr),
    .en_i  (state_q == S_CMPL),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    mepc_d      = mepc_q;
    mstatus_d   = mstatus_q;
    id_d        = id_q;
    cause_ext_d = cause_ext_q;
    cmpl_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inst_mret_i && !int_busy_i) begin
          state_d     = S_MSTATUS;
          mepc_d      = csr_mepc_i;
          mstatus_d   = csr_mstatus_i;
          id_d        = int_id_i;
          cause_ext_d = ((csr_mcause_i & 32'h7fff_ffff) == 32'(MCAUSE_EXT_INT));
        end
      end
      S_MSTATUS: state_d = cause_ext_q ? S_CMPL : S_JUMP;
      S_CMPL: begin
        // A handshake in the terminal-count cycle still counts as success.
        if (cmpl_ready_i) begin
          state_d = S_JUMP;
        end else if (tmo_tc) begin
          state_d    = S_JUMP;
          cmpl_err_d = 1'b1;
        end
      end
      S_JUMP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with the state they belong to.
    csr_we_d     = (state_d == S_MSTATUS);
    csr_waddr_d  = csr_we_d ? {20'h0, CSR_MSTATUS} : 32'h0;
    csr_wdata_d  = csr_we_d ? mstatus_ret(mstatus_d) : 32'h0;
    cmpl_valid_d = (state_d == S_CMPL);
    cmpl_id_d    = cmpl_valid_d ? id_d : '0;
    int_assert_d = (state_d == S_JUMP);
    int_addr_d   = int_assert_d ? ret_addr(mepc_d) : 32'h0;
  end

  assign tmo_clr = (state_d == S_CMPL) && (state_q != S_CMPL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mepc_q       <= 32'h0;
      mstatus_q    <= 32'h0;
      id_q         <= '0;
      cause_ext_q  <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= 32'h0;
      csr_wdata_q  <= 32'h0;
      cmpl_valid_q <= 1'b0;
      cmpl_id_q    <= '0;
      cmpl_err_q   <= 1'b0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      mepc_q       <= mepc_d;
      mstatus_q    <= mstatus_d;
      id_q         <= id_d;
      cause_ext_q  <= cause_ext_d;
      csr_we_q     <= csr_we_d;
      csr_waddr_q  <= csr_waddr_d;
      csr_wdata_q  <= csr_wdata_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_id_q    <= cmpl_id_d;
      cmpl_err_q   <= cmpl_err_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign csr_we_o     = csr_we_q;
  assign csr_waddr_o  = csr_waddr_q;
  assign csr_wdata_o  = csr_wdata_q;
  assign cmpl_valid_o = cmpl_valid_q;
  assign cmpl_id_o    = cmpl_id_q;
  assign cmpl_err_o   = cmpl_err_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;
  assign stall_flag_o = (state_q != S_IDLE) || inst_mret_i;

endmodule
